spi_sram_responder: RTL

- Synthesizable serial-SRAM device model: the responder end of the one-bit serial memory link driven by the CPU's memory controller.
- Decodes command, address and data frames on cs/si, drives so, and holds a word-organised storage array.
- Used on FPGA bring-up and in system simulation in place of the external SRAM chip.
- Includes a backdoor port for program preload.

---
 rtl/micro1_pkg.sv | 25 ++
 rtl/spi_sram_array.sv | 45 ++++
 rtl/spi_sram_responder.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/micro1_pkg.sv
// Shared constants and types for the serial-SRAM responder.
package micro1_pkg;

  localparam int WORD_SIZE            = 16;
  localparam int ADDRESS_LEN          = 17;
  localparam int ADDRESS_IGNORED_BITS = 7;

  localparam logic [7:0] CMD_READ  = 8'h03;
  localparam logic [7:0] CMD_WRITE = 8'h02;

  // Frame bit indices at which each field ends; the counter saturates at CNT_SAT.
  localparam logic [5:0] CMD_END  = 6'd7;
  localparam logic [5:0] ADDR_END = 6'd31;
  localparam logic [5:0] DATA_END = 6'd47;
  localparam logic [5:0] CNT_SAT  = 6'd48;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DATA,
    ST_IGNORE
  } state_t;

endpackage

// File: rtl/spi_sram_array.sv
// Word storage for the serial-SRAM responder: one synchronous write port fed
// by a frame-over-backdoor priority mux, one combinational read port.
module spi_sram_array #(
  parameter int DEPTH_WORDS = 256,
  parameter int WORD_SIZE   = 16,
  parameter int IDX_W       = 8
) (
  input  logic                 clk,
  input  logic                 frame_we,
  input  logic [IDX_W-1:0]     frame_idx,
  input  logic [WORD_SIZE-1:0] frame_wdata,
  input  logic                 bd_we,
  input  logic [IDX_W-1:0]     bd_idx,
  input  logic [WORD_SIZE-1:0] bd_wdata,
  input  logic [IDX_W-1:0]     rd_idx,
  output logic [WORD_SIZE-1:0] rd_data
);

  logic [WORD_SIZE-1:0] mem [DEPTH_WORDS];

  logic                 wr_en;
  logic [IDX_W-1:0]     wr_idx;
  logic [WORD_SIZE-1:0] wr_data;

  // Single write port: a frame commit takes the port; the backdoor only gets it when no frame commits.
  always_comb begin
    wr_en   = frame_we | bd_we;
    wr_idx  = bd_idx;
    wr_data = bd_wdata;
    if (frame_we) begin
      wr_idx  = frame_idx;
      wr_data = frame_wdata;
    end
  end

  // Storage write; contents are never cleared by reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_idx] <= wr_data;
    end
  end

  assign rd_data = mem[rd_idx];

endmodule

// File: rtl/spi_sram_responder.sv
// Responder end of the one-bit serial SRAM link: decodes cmd/address/data
// frames on sram_cs/sram_si, drives sram_so and holds the word array.
// Optional build macro MICRO1_SRAM_SEQ_EN: sequential mode, where a frame that
// keeps cs low past the first data word continues on consecutive words.
module spi_sram_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int WORD_SIZE   = micro1_pkg::WORD_SIZE,
  parameter int ADDRESS_LEN = micro1_pkg::ADDRESS_LEN
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ena,
  input  logic                   sram_cs,
  input  logic                   sram_si,
  output logic                   sram_so,
  input  logic                   bd_we,
  input  logic [ADDRESS_LEN-1:0] bd_addr,
  input  logic [WORD_SIZE-1:0]   bd_wdata,
  output logic                   busy,
  output logic                   cmd_error
);

  import micro1_pkg::*;

  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  state_t               state_reg,   state_next;
  logic [5:0]           cnt_reg,     cnt_next;
  logic [6:0]           cmd_reg,     cmd_next;
  logic [IDX_W-1:0]     addr_reg,    addr_next;
  logic [IDX_W-1:0]     idx_reg,     idx_next;
  logic                 is_read_reg, is_read_next;
  logic [WORD_SIZE-1:0] rshift_reg,  rshift_next;
  logic [WORD_SIZE-1:0] wshift_reg,  wshift_next;
  logic                 so_reg,      so_next;
  logic                 err_reg,     err_next;

  logic [7:0]           cmd_full;
  logic [WORD_SIZE-1:0] wdata_full;
  logic                 frame_we;
  logic [IDX_W-1:0]     rd_idx;
  logic [WORD_SIZE-1:0] rd_data;
  logic                 bd_addr_unused;

  // Command byte including the bit being sampled now.
  assign cmd_full   = {cmd_reg, sram_si};
  // Data word including the bit being sampled now (LSB first, so new bits enter at the top).
  assign wdata_full = (wshift_reg >> 1) | {sram_si, {(WORD_SIZE-1){1'b0}}};

  // Only the word-index bits of the backdoor address select storage.
  assign bd_addr_unused = ^bd_addr;

  // Frame decoder: next state, counter, shifters and serial output.
  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    cmd_next     = cmd_reg;
    addr_next    = addr_reg;
    idx_next     = idx_reg;
    is_read_next = is_read_reg;
    rshift_next  = rshift_reg;
    wshift_next  = wshift_reg;
    so_next      = so_reg;
    err_next     = err_reg;
    frame_we     = 1'b0;
    rd_idx       = idx_reg;

    if (sram_cs) begin
      // Deselect ends any frame; an uncommitted write is simply dropped.
      state_next = ST_IDLE;
      cnt_next   = '0;
      so_next    = 1'b0;
    end else begin
      cnt_next = (cnt_reg == CNT_SAT) ? CNT_SAT : cnt_reg + 6'd1;
      case (state_reg)
        ST_IDLE, ST_CMD: begin
          state_next = ST_CMD;
          cmd_next   = cmd_full[6:0];
          so_next    = 1'b0;
          if (cnt_reg == CMD_END) begin
            if (cmd_full == CMD_READ) begin
              is_read_next = 1'b1;
              state_next   = ST_ADDR;
            end else if (cmd_full == CMD_WRITE) begin
              is_read_next = 1'b0;
              state_next   = ST_ADDR;
            end else begin
              err_next   = 1'b1;
              state_next = ST_IGNORE;
            end
          end
        end

        ST_ADDR: begin
          // Only the low address bits above bit 0 survive the shift; upper bits alias.
          addr_next = (addr_reg << 1) | IDX_W'(sram_si);
          if (cnt_reg == ADDR_END) begin
            // The bit sampled now is address bit 0, which does not affect the word index.
            state_next = ST_DATA;
            idx_next   = addr_reg;
            rd_idx     = addr_reg;
            if (is_read_reg) begin
              so_next     = rd_data[0];
              rshift_next = rd_data >> 1;
            end
          end
        end

        ST_DATA: begin
          wshift_next = wdata_full;
          if (is_read_reg) begin
            so_next     = rshift_reg[0];
            rshift_next = rshift_reg >> 1;
          end
          if (cnt_reg == DATA_END) begin
            frame_we = !is_read_reg;
`ifdef MICRO1_SRAM_SEQ_EN
            // Continue on the next word (wrapping) and restart at data bit 0.
            idx_next = idx_reg + IDX_W'(1);
            rd_idx   = idx_reg + IDX_W'(1);
            cnt_next = ADDR_END + 6'd1;
            if (is_read_reg) begin
              so_next     = rd_data[0];
              rshift_next = rd_data >> 1;
            end
`else
            state_next = ST_IGNORE;
            so_next    = 1'b0;
`endif
          end
        end

        ST_IGNORE: begin
          so_next = 1'b0;
        end

        default: begin
          state_next = ST_IDLE;
          so_next    = 1'b0;
        end
      endcase
    end
  end

  // State and datapath registers; everything holds while ena is low.
  always_ff @(posedge clk) begin
    if (ena) begin
      if (rst) begin
        state_reg   <= ST_IDLE;
        cnt_reg     <= '0;
        cmd_reg     <= '0;
        addr_reg    <= '0;
        idx_reg     <= '0;
        is_read_reg <= 1'b0;
        rshift_reg  <= '0;
        wshift_reg  <= '0;
        so_reg      <= 1'b0;
        err_reg     <= 1'b0;
      end else begin
        state_reg   <= state_next;
        cnt_reg     <= cnt_next;
        cmd_reg     <= cmd_next;
        addr_reg    <= addr_next;
        idx_reg     <= idx_next;
        is_read_reg <= is_read_next;
        rshift_reg  <= rshift_next;
        wshift_reg  <= wshift_next;
        so_reg      <= so_next;
        err_reg     <= err_next;
      end
    end
  end

  spi_sram_array #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .WORD_SIZE  (WORD_SIZE),
    .IDX_W      (IDX_W)
  ) u_array (
    .clk        (clk),
    .frame_we   (frame_we & ena & ~rst),
    .frame_idx  (idx_reg),
    .frame_wdata(wdata_full),
    .bd_we      (bd_we & ena & ~rst),
    .bd_idx     (bd_addr[1 +: IDX_W]),
    .bd_wdata   (bd_wdata),
    .rd_idx     (rd_idx),
    .rd_data    (rd_data)
  );

  assign sram_so   = so_reg;
  assign cmd_error = err_reg;
  assign busy      = !rst && !sram_cs && (state_reg != ST_IGNORE);

endmodule
